// File: rtl/vga_fbuff_arb_pkg.sv
// rtl/vga_fbuff_arb_pkg.sv - shared types for the frame buffer arbiter
package vga_fbuff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_DISP,
        OWNER_HOST
    } arb_owner_t;

endpackage

// File: rtl/vga_fbuff_arbiter.sv
// rtl/vga_fbuff_arbiter.sv - display/host arbiter for the single frame buffer port
// Display has fixed priority; the loss counter hands the host the next win after HOST_MAX_LOSS losses.
module vga_fbuff_arbiter
    import vga_fbuff_arb_pkg::*;
#(
    parameter int FBUFF_ADDR_WIDTH = 15,
    parameter int FBUFF_DATA_WIDTH = 48,
    parameter int FBUFF_LATENCY    = 1,
    parameter int HOST_MAX_LOSS    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        disp_rd_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] disp_addr_i,
    output logic                        disp_rd_rsp_o,
    output logic [FBUFF_DATA_WIDTH-1:0] disp_data_o,
    input  logic                        host_req_i,
    input  logic                        host_we_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] host_addr_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] host_data_i,
    output logic                        host_ack_o,
    output logic [FBUFF_DATA_WIDTH-1:0] host_data_o,
    output logic                        fbuff_en_o,
    output logic                        fbuff_we_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i
);

    localparam int LAT_W  = $clog2(FBUFF_LATENCY + 1);
    localparam int LOSS_W = $clog2(HOST_MAX_LOSS + 1);
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(FBUFF_LATENCY);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(1);
    localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(HOST_MAX_LOSS);

    arb_state_t                  state_q, state_d;
    arb_owner_t                  owner_q, owner_d;
    logic [LAT_W-1:0]            lat_cnt_q, lat_cnt_d;
    logic [LOSS_W-1:0]           loss_cnt_q, loss_cnt_d;
    logic                        fbuff_en_q, fbuff_en_d;
    logic                        fbuff_we_q, fbuff_we_d;
    logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_q, fbuff_addr_d;
    logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_q, fbuff_data_d;
    logic                        disp_rd_rsp_q, disp_rd_rsp_d;
    logic [FBUFF_DATA_WIDTH-1:0] disp_data_q, disp_data_d;
    logic                        host_ack_q, host_ack_d;
    logic [FBUFF_DATA_WIDTH-1:0] host_data_q, host_data_d;
    logic                        host_wins;

    // The fbuff_* registers double as the latched winner request, so the
    // ISSUE cycle drives the port straight from flops.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        lat_cnt_d     = lat_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        fbuff_en_d    = 1'b0;
        fbuff_we_d    = 1'b0;
        fbuff_addr_d  = fbuff_addr_q;
        fbuff_data_d  = fbuff_data_q;
        disp_rd_rsp_d = 1'b0;
        disp_data_d   = disp_data_q;
        host_ack_d    = 1'b0;
        host_data_d   = host_data_q;
        host_wins     = 1'b0;

        case (state_q)
            IDLE: begin
                if (disp_rd_req_i || host_req_i) begin
                    host_wins  = host_req_i && (!disp_rd_req_i || loss_cnt_q == LOSS_MAX);
                    fbuff_en_d = 1'b1;
                    state_d    = ISSUE;
                    if (host_wins) begin
                        owner_d      = OWNER_HOST;
                        fbuff_addr_d = host_addr_i;
                        fbuff_data_d = host_data_i;
                        fbuff_we_d   = host_we_i;
                        loss_cnt_d   = '0;
                    end else begin
                        owner_d      = OWNER_DISP;
                        fbuff_addr_d = disp_addr_i;
                        if (host_req_i && loss_cnt_q != LOSS_MAX) begin
                            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_INIT;
                if (fbuff_we_q) begin
                    host_ack_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    if (owner_q == OWNER_HOST) begin
                        host_data_d = fbuff_data_i;
                        host_ack_d  = 1'b1;
                    end else begin
                        disp_data_d   = fbuff_data_i;
                        disp_rd_rsp_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            owner_q       <= OWNER_DISP;
            lat_cnt_q     <= '0;
            loss_cnt_q    <= '0;
            fbuff_en_q    <= 1'b0;
            fbuff_we_q    <= 1'b0;
            fbuff_addr_q  <= '0;
            fbuff_data_q  <= '0;
            disp_rd_rsp_q <= 1'b0;
            disp_data_q   <= '0;
            host_ack_q    <= 1'b0;
            host_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            lat_cnt_q     <= lat_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            fbuff_en_q    <= fbuff_en_d;
            fbuff_we_q    <= fbuff_we_d;
            fbuff_addr_q  <= fbuff_addr_d;
            fbuff_data_q  <= fbuff_data_d;
            disp_rd_rsp_q <= disp_rd_rsp_d;
            disp_data_q   <= disp_data_d;
            host_ack_q    <= host_ack_d;
            host_data_q   <= host_data_d;
        end
    end

    assign disp_rd_rsp_o = disp_rd_rsp_q;
    assign disp_data_o   = disp_data_q;
    assign host_ack_o    = host_ack_q;
    assign host_data_o   = host_data_q;
    assign fbuff_en_o    = fbuff_en_q;
    assign fbuff_we_o    = fbuff_we_q;
    assign fbuff_addr_o  = fbuff_addr_q;
    assign fbuff_data_o  = fbuff_data_q;

endmodule

// File: tb/tb_vga_fbuff_arbiter.sv
// tb/tb_vga_fbuff_arbiter.sv - scoreboard bench for vga_fbuff_arbiter
module tb_vga_fbuff_arbiter;

    localparam int AW = 15;
    localparam int DW = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t fb_a_q[$], disp_a_q[$], host_a_q[$], fb_b_q[$], disp_c_q[$];
    exp_t me;

    logic rst = 1'b1;

    logic          dreq_a = 0, drsp_a, hreq_a = 0, hwe_a = 0, hack_a, en_a, we_a;
    logic [AW-1:0] daddr_a = '0, haddr_a = '0, addr_a;
    logic [DW-1:0] ddata_a, hwdata_a = '0, hrdata_a, wdata_a, rdata_a;

    logic          dreq_b = 0, drsp_b, hreq_b = 0, hwe_b = 0, hack_b, en_b, we_b;
    logic [AW-1:0] daddr_b = '0, haddr_b = '0, addr_b;
    logic [DW-1:0] ddata_b, hwdata_b = '0, hrdata_b, wdata_b, rdata_b;

    logic          dreq_c = 0, drsp_c, hreq_c = 0, hwe_c = 0, hack_c, en_c, we_c;
    logic [AW-1:0] daddr_c = '0, haddr_c = '0, addr_c;
    logic [DW-1:0] ddata_c, hwdata_c = '0, hrdata_c, wdata_c, rdata_c;

    vga_fbuff_arbiter dut_a (
        .clk_i(clk), .rst_i(rst),
        .disp_rd_req_i(dreq_a), .disp_addr_i(daddr_a), .disp_rd_rsp_o(drsp_a), .disp_data_o(ddata_a),
        .host_req_i(hreq_a), .host_we_i(hwe_a), .host_addr_i(haddr_a), .host_data_i(hwdata_a),
        .host_ack_o(hack_a), .host_data_o(hrdata_a),
        .fbuff_en_o(en_a), .fbuff_we_o(we_a), .fbuff_addr_o(addr_a), .fbuff_data_o(wdata_a),
        .fbuff_data_i(rdata_a)
    );

    vga_fbuff_arbiter #(.HOST_MAX_LOSS(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .disp_rd_req_i(dreq_b), .disp_addr_i(daddr_b), .disp_rd_rsp_o(drsp_b), .disp_data_o(ddata_b),
        .host_req_i(hreq_b), .host_we_i(hwe_b), .host_addr_i(haddr_b), .host_data_i(hwdata_b),
        .host_ack_o(hack_b), .host_data_o(hrdata_b),
        .fbuff_en_o(en_b), .fbuff_we_o(we_b), .fbuff_addr_o(addr_b), .fbuff_data_o(wdata_b),
        .fbuff_data_i(rdata_b)
    );

    vga_fbuff_arbiter #(.FBUFF_LATENCY(3)) dut_c (
        .clk_i(clk), .rst_i(rst),
        .disp_rd_req_i(dreq_c), .disp_addr_i(daddr_c), .disp_rd_rsp_o(drsp_c), .disp_data_o(ddata_c),
        .host_req_i(hreq_c), .host_we_i(hwe_c), .host_addr_i(haddr_c), .host_data_i(hwdata_c),
        .host_ack_o(hack_c), .host_data_o(hrdata_c),
        .fbuff_en_o(en_c), .fbuff_we_o(we_c), .fbuff_addr_o(addr_c), .fbuff_data_o(wdata_c),
        .fbuff_data_i(rdata_c)
    );

    // Frame buffer model for dut_a: one-cycle read latency.
    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (en_a === 1'b1) begin
            if (we_a) mem_a[addr_a] <= wdata_a;
            rdata_a <= mem_a[addr_a];
        end
    end

    assign rdata_b = '0;
    // A changing value per cycle shows which WAIT cycle dut_c captured.
    assign rdata_c = {16'hC0DE, 32'(cyc)};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output pulse with no expected entry at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        if (en_a === 1'b1) begin
            if (fb_a_q.size() == 0) unexpected("fb_a");
            else begin
                me = fb_a_q.pop_front();
                chk("fb_a", 256'({cyc, we_a, addr_a, me.we ? wdata_a : DW'(0)}),
                            256'({me.cyc, me.we, me.addr, me.we ? me.data : DW'(0)}));
            end
        end
        if (drsp_a === 1'b1) begin
            if (disp_a_q.size() == 0) unexpected("disp_a");
            else begin
                me = disp_a_q.pop_front();
                chk("disp_a", 256'({cyc, ddata_a}), 256'({me.cyc, me.data}));
            end
        end
        if (hack_a === 1'b1) begin
            if (host_a_q.size() == 0) unexpected("host_a");
            else begin
                me = host_a_q.pop_front();
                chk("host_a", 256'({cyc, me.we ? DW'(0) : hrdata_a}),
                              256'({me.cyc, me.we ? DW'(0) : me.data}));
            end
        end
        if (en_b === 1'b1) begin
            if (fb_b_q.size() == 0) unexpected("grant_b");
            else begin
                me = fb_b_q.pop_front();
                chk("grant_b", 256'({cyc, we_b}), 256'({me.cyc, me.we}));
            end
        end
        if (drsp_c === 1'b1) begin
            if (disp_c_q.size() == 0) unexpected("disp_c");
            else begin
                me = disp_c_q.pop_front();
                chk("disp_c", 256'({cyc, ddata_c}), 256'({me.cyc, me.data}));
            end
        end
    end

    function automatic exp_t mk(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t r;
        r.cyc = c; r.we = w; r.addr = a; r.data = d;
        return r;
    endfunction

    task automatic wait_disp_a();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (drsp_a === 1'b1);
        end
        if (!got) begin checks++; errors++; $display("FAIL disp_a_timeout: no response, required within 40 cycles"); end
        dreq_a = 0;
    endtask

    task automatic wait_host_a();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (hack_a === 1'b1);
        end
        if (!got) begin checks++; errors++; $display("FAIL host_a_timeout: no ack, required within 40 cycles"); end
        hreq_a = 0;
        hwe_a  = 0;
    endtask

    task automatic wait_disp_c();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (drsp_c === 1'b1);
        end
        if (!got) begin checks++; errors++; $display("FAIL disp_c_timeout: no response, required within 40 cycles"); end
        dreq_c = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        mem_a[15'h0010] = 48'h0123_4567_89AB;
        mem_a[15'h0020] = 48'h5A5A_0000_A5A5;

        repeat (3) @(negedge clk);
        chk("reset_a", 256'({drsp_a, ddata_a, hack_a, hrdata_a, en_a, we_a, addr_a, wdata_a}), 256'(0));
        chk("reset_b", 256'({drsp_b, ddata_b, hack_b, hrdata_b, en_b, we_b, addr_b, wdata_b}), 256'(0));
        chk("reset_c", 256'({drsp_c, ddata_c, hack_c, hrdata_c, en_c, we_c, addr_c, wdata_c}), 256'(0));
        rst = 0;

        // Display read
        @(negedge clk); t = cyc;
        fb_a_q.push_back(mk(t + 1, 0, 15'h0010, '0));
        disp_a_q.push_back(mk(t + 3, 0, '0, 48'h0123_4567_89AB));
        daddr_a = 15'h0010; dreq_a = 1;
        wait_disp_a();

        // Host write then read back
        @(negedge clk); t = cyc;
        fb_a_q.push_back(mk(t + 1, 1, 15'h4AFF, 48'hABCD_EF01_2345));
        host_a_q.push_back(mk(t + 2, 1, '0, '0));
        haddr_a = 15'h4AFF; hwdata_a = 48'hABCD_EF01_2345; hwe_a = 1; hreq_a = 1;
        wait_host_a();
        @(negedge clk); t = cyc;
        fb_a_q.push_back(mk(t + 1, 0, 15'h4AFF, '0));
        host_a_q.push_back(mk(t + 3, 0, '0, 48'hABCD_EF01_2345));
        haddr_a = 15'h4AFF; hwdata_a = '0; hwe_a = 0; hreq_a = 1;
        wait_host_a();

        // Simultaneous requests
        @(negedge clk); t = cyc;
        fb_a_q.push_back(mk(t + 1, 0, 15'h0010, '0));
        disp_a_q.push_back(mk(t + 3, 0, '0, 48'h0123_4567_89AB));
        fb_a_q.push_back(mk(t + 5, 1, 15'h0123, 48'h1111_2222_3333));
        host_a_q.push_back(mk(t + 6, 1, '0, '0));
        daddr_a = 15'h0010; dreq_a = 1;
        haddr_a = 15'h0123; hwdata_a = 48'h1111_2222_3333; hwe_a = 1; hreq_a = 1;
        fork
            wait_disp_a();
            begin
                @(negedge clk);
                chk("loss_after_disp_win", 256'(dut_a.loss_cnt_q), 256'(1));
                wait_host_a();
            end
        join
        @(negedge clk);
        chk("loss_after_host_win", 256'(dut_a.loss_cnt_q), 256'(0));

        // Reset during WAIT drops the read
        @(negedge clk); t = cyc;
        fb_a_q.push_back(mk(t + 1, 0, 15'h0010, '0));
        daddr_a = 15'h0010; dreq_a = 1;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("reset_mid_read", 256'({drsp_a, ddata_a, hack_a, hrdata_a, en_a, we_a, addr_a, wdata_a}), 256'(0));
        rst = 0; dreq_a = 0;
        repeat (3) @(negedge clk);
        t = cyc;
        fb_a_q.push_back(mk(t + 1, 0, 15'h0020, '0));
        disp_a_q.push_back(mk(t + 3, 0, '0, 48'h5A5A_0000_A5A5));
        daddr_a = 15'h0020; dreq_a = 1;
        wait_disp_a();

        // Starvation guard, HOST_MAX_LOSS = 2: D D H D D H
        @(negedge clk); t = cyc;
        fb_b_q.push_back(mk(t + 1,  0, '0, '0));
        fb_b_q.push_back(mk(t + 5,  0, '0, '0));
        fb_b_q.push_back(mk(t + 9,  1, '0, '0));
        fb_b_q.push_back(mk(t + 12, 0, '0, '0));
        fb_b_q.push_back(mk(t + 16, 0, '0, '0));
        fb_b_q.push_back(mk(t + 20, 1, '0, '0));
        daddr_b = 15'h0040; dreq_b = 1;
        haddr_b = 15'h7FFF; hwdata_b = 48'hFEED_0000_BEEF; hwe_b = 1; hreq_b = 1;
        repeat (20) @(negedge clk);
        dreq_b = 0; hreq_b = 0; hwe_b = 0;
        repeat (4) @(negedge clk);

        // Latency 3: data from the third WAIT cycle, response at T+5
        @(negedge clk); t = cyc;
        disp_c_q.push_back(mk(t + 5, 0, '0, {16'hC0DE, 32'(t + 4)}));
        daddr_c = 15'h0005; dreq_c = 1;
        wait_disp_c();

        repeat (6) @(negedge clk);
        chk("fb_a_left",   256'(fb_a_q.size()),   256'(0));
        chk("disp_a_left", 256'(disp_a_q.size()), 256'(0));
        chk("host_a_left", 256'(host_a_q.size()), 256'(0));
        chk("fb_b_left",   256'(fb_b_q.size()),   256'(0));
        chk("disp_c_left", 256'(disp_c_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
